// File: rtl/thread_fetch_unit.sv
// Multi-hart instruction fetch unit: per-hart PC file, one outstanding memory request at a time.
// Define FETCH_PERF_CNT_EN to build the saturating delivered-instruction counter on fetch_cnt_o.
module thread_fetch_unit #(
    parameter int          NUM_THREADS       = 4,
    parameter int          THREAD_ADDR_WIDTH = 2,
    parameter logic [31:0] BOOT_ADDR         = 32'h0000_0080
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [THREAD_ADDR_WIDTH-1:0] hart_sel_i,
    input  logic                         stall_i,
    input  logic                         redirect_valid_i,
    input  logic [THREAD_ADDR_WIDTH-1:0] redirect_hart_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic                         instr_req_o,
    output logic [31:0]                  instr_addr_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    input  logic [31:0]                  instr_rdata_i,
    output logic                         instr_valid_o,
    output logic [31:0]                  instr_o,
    output logic [31:0]                  pc_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_o,
    output logic                         busy_o,
    output logic [31:0]                  fetch_cnt_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                         state, state_nxt;
    logic [31:0]                    pc [NUM_THREADS];
    logic [THREAD_ADDR_WIDTH-1:0]   hart_q;
    logic [31:0]                    addr_q;
    logic                           kill_q, kill_nxt;
    logic                           redirect_hit;
    logic                           killed;
    logic                           launch;
    logic                           capture;
    logic                           deliver;
    logic                           hold_keep;

    assign redirect_hit = redirect_valid_i && (redirect_hart_i == hart_q);
    // A redirect arriving in the same cycle as rvalid must also discard the response.
    assign killed       = kill_q || redirect_hit;
    assign hold_keep    = (state == HOLD) && stall_i && !redirect_hit;

    assign instr_req_o  = (state == REQ);
    assign instr_addr_o = addr_q;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            kill_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            kill_q <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill_q;
        launch    = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                kill_nxt = 1'b0;
                if (enable && !stall_i) begin
                    launch    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect_hit) kill_nxt = 1'b1;
                if (instr_gnt_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (redirect_hit) kill_nxt = 1'b1;
                if (instr_rvalid_i) begin
                    kill_nxt = 1'b0;
                    if (killed) begin
                        state_nxt = IDLE;
                    end else begin
                        capture = 1'b1;
                        if (stall_i) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = IDLE;
                            deliver   = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect_hit) begin
                    state_nxt = IDLE;
                end else if (!stall_i) begin
                    state_nxt = IDLE;
                    deliver   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Redirect has priority over the post-delivery increment on the same hart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) pc[i] <= BOOT_ADDR;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (redirect_valid_i && (redirect_hart_i == THREAD_ADDR_WIDTH'(i)))
                    pc[i] <= redirect_pc_i;
                else if (deliver && (hart_q == THREAD_ADDR_WIDTH'(i)))
                    pc[i] <= pc[i] + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hart_q        <= '0;
            addr_q        <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            hart_o        <= '0;
        end else begin
            if (launch) begin
                hart_q <= hart_sel_i;
                addr_q <= pc[hart_sel_i];
            end
            if (capture) begin
                instr_o <= instr_rdata_i;
                pc_o    <= addr_q;
                hart_o  <= hart_q;
            end
            instr_valid_o <= capture || hold_keep;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (deliver && (cnt_q != 32'hFFFF_FFFF))
            cnt_q <= cnt_q + 32'd1;
    end

    assign fetch_cnt_o = cnt_q;
`else
    assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Randomized self-checking bench for thread_fetch_unit against a transaction-level PC/delivery model.
module tb_thread_fetch_unit;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  hart_sel_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [1:0]  redirect_hart_i;
    logic [31:0] redirect_pc_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [1:0]  hart_o;
    logic        busy_o;
    logic [31:0] fetch_cnt_o;

    thread_fetch_unit #(
        .NUM_THREADS(NT),
        .THREAD_ADDR_WIDTH(2),
        .BOOT_ADDR(32'h0000_0080)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .hart_sel_i(hart_sel_i),
        .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_hart_i(redirect_hart_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o(instr_o),
        .pc_o(pc_o),
        .hart_o(hart_o),
        .busy_o(busy_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    int          checksTotal  = 0;
    int          checksPassed = 0;
    logic [31:0] modelPc [NT];
    int          deliveredCnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    endtask

    function automatic logic [31:0] expCnt();
`ifdef FETCH_PERF_CNT_EN
        return 32'(deliveredCnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NT; i++) modelPc[i] = 32'h0000_0080;
        deliveredCnt = 0;
    endtask

    // Drives the handshake inputs and scrambles everything that should be ignored.
    task automatic applyStimulus(input logic en, input logic st, input logic gn, input logic rv);
        enable           = en;
        stall_i          = st;
        instr_gnt_i      = gn;
        instr_rvalid_i   = rv;
        redirect_valid_i = 1'b0;
        redirect_hart_i  = 2'($urandom);
        redirect_pc_i    = $urandom;
        hart_sel_i       = 2'($urandom);
        instr_rdata_i    = $urandom;
    endtask

    task automatic doRedirect(input int hh, input logic [31:0] target);
        redirect_valid_i = 1'b1;
        redirect_hart_i  = 2'(hh);
        redirect_pc_i    = target;
        modelPc[hh]      = target;
    endtask

    // mode: 0 none, 1 same-hart redirect in REQ, 2 same in WAIT, 3 other in WAIT,
    //       4 same in HOLD, 5 other in HOLD.
    task automatic runFetch(input int h, input int gntDelay, input int rvDelay, input int stallCycles,
                            input int mode, input int other, input logic [31:0] target,
                            input logic [31:0] data);
        logic [31:0] expAddr;
        bit          killed  = 0;
        bit          aborted = 0;
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        hart_sel_i = 2'(h);
        expAddr    = modelPc[h];
        @(negedge clk);
        for (int k = 0; k <= gntDelay; k++) begin
            checkOutput("req", 32'(instr_req_o), 32'd1);
            checkOutput("req_addr", instr_addr_o, expAddr);
            checkOutput("req_valid", 32'(instr_valid_o), 32'd0);
            applyStimulus(1'($urandom), 1'($urandom), 1'(k == gntDelay), 1'b0);
            if (k == 0 && mode == 1) begin
                doRedirect(h, target);
                killed = 1;
            end
            @(negedge clk);
        end
        for (int k = 0; k <= rvDelay; k++) begin
            checkOutput("wait_req", 32'(instr_req_o), 32'd0);
            checkOutput("wait_busy", 32'(busy_o), 32'd1);
            if (k == rvDelay) begin
                applyStimulus(1'($urandom), 1'(stallCycles > 0), 1'b0, 1'b1);
                instr_rdata_i = data;
            end else begin
                applyStimulus(1'($urandom), 1'($urandom), 1'b0, 1'b0);
            end
            if (k == 0 && mode == 2) begin
                doRedirect(h, target);
                killed = 1;
            end
            if (k == 0 && mode == 3) doRedirect(other, target);
            @(negedge clk);
        end
        if (killed) begin
            checkOutput("kill_valid", 32'(instr_valid_o), 32'd0);
            checkOutput("kill_busy", 32'(busy_o), 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end else if (stallCycles == 0) begin
            checkOutput("valid", 32'(instr_valid_o), 32'd1);
            checkOutput("instr", instr_o, data);
            checkOutput("pc_o", pc_o, expAddr);
            checkOutput("hart_o", 32'(hart_o), 32'(h));
            modelPc[h] = modelPc[h] + 32'd4;
            deliveredCnt++;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("pulse_end", 32'(instr_valid_o), 32'd0);
            checkOutput("pulse_busy", 32'(busy_o), 32'd0);
        end else begin
            for (int k = 0; k < stallCycles && !aborted; k++) begin
                checkOutput("hold_valid", 32'(instr_valid_o), 32'd1);
                checkOutput("hold_instr", instr_o, data);
                checkOutput("hold_pc", pc_o, expAddr);
                checkOutput("hold_hart", 32'(hart_o), 32'(h));
                applyStimulus(1'($urandom), 1'(k < stallCycles - 1), 1'b0, 1'b0);
                if (k == 0 && mode == 4) begin
                    stall_i = 1'b1;
                    doRedirect(h, target);
                    aborted = 1;
                end
                if (k == 0 && mode == 5) doRedirect(other, target);
                @(negedge clk);
            end
            checkOutput("hold_end", 32'(instr_valid_o), 32'd0);
            checkOutput("hold_busy", 32'(busy_o), 32'd0);
            if (!aborted) begin
                modelPc[h] = modelPc[h] + 32'd4;
                deliveredCnt++;
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fetch_cnt", fetch_cnt_o, expCnt());
    endtask

    task automatic resetMidFetch();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        hart_sel_i = 2'd1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_req", 32'(instr_req_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_addr", instr_addr_o, 32'd0);
        checkOutput("rst_cnt", fetch_cnt_o, 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int h, o, st, md;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_req", 32'(instr_req_o), 32'd0);
        checkOutput("reset_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_addr", instr_addr_o, 32'd0);
        checkOutput("reset_instr", instr_o, 32'd0);
        checkOutput("reset_pc", pc_o, 32'd0);
        checkOutput("reset_hart", 32'(hart_o), 32'd0);
        checkOutput("reset_cnt", fetch_cnt_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        runFetch(2, 0, 0, 0, 0, 0, 32'd0, 32'h0000_0013);
        runFetch(2, 0, 0, 0, 0, 0, 32'd0, $urandom);

        // Fetch must not start while disabled or while decode stalls.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("disabled_req", 32'(instr_req_o), 32'd0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("stalled_busy", 32'(busy_o), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        runFetch(0, 3, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(1, 0, 0, 5, 0, 0, 32'd0, $urandom);
        runFetch(1, 0, 1, 0, 2, 0, 32'h0000_0200, $urandom);
        runFetch(1, 0, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(0, 1, 1, 0, 3, 3, 32'h0000_0400, $urandom);
        runFetch(3, 0, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(0, 0, 0, 0, 3, 2, 32'hFFFF_FFFC, $urandom);
        runFetch(2, 0, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(2, 1, 0, 2, 0, 0, 32'd0, $urandom);
        runFetch(2, 0, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(3, 2, 0, 0, 1, 0, 32'h0000_1000, $urandom);
        runFetch(0, 0, 0, 3, 4, 0, 32'h0000_2000, $urandom);
        runFetch(0, 0, 2, 3, 5, 1, 32'h0000_3000, $urandom);

        for (int n = 0; n < 60; n++) begin
            h  = $urandom_range(0, 3);
            o  = (h + 1 + $urandom_range(0, 2)) % NT;
            st = $urandom_range(0, 3);
            md = $urandom_range(0, 5);
            if (md >= 4 && st == 0) st = 1;
            runFetch(h, $urandom_range(0, 3), $urandom_range(0, 3), st, md, o,
                     $urandom & 32'hFFFF_FFFC, $urandom);
        end

        resetMidFetch();
        runFetch(1, 0, 0, 0, 0, 0, 32'd0, $urandom);
        runFetch(3, 1, 1, 1, 0, 0, 32'd0, $urandom);
        checkOutput("final_cnt", fetch_cnt_o, expCnt());

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/thread_fetch_unit.md
THREAD_FETCH_UNIT -- requirements
Module: thread_fetch_unit

Interface
REQ-001 SHALL have parameters:
- NUM_THREADS, default 4 (riscv_defines), number of harts.
- THREAD_ADDR_WIDTH, default 2 (riscv_defines), hart index width.
- BOOT_ADDR, default 32'h0000_0080, reset PC of every hart.

REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  fetch permitted.
- hart_sel_i  in  THREAD_ADDR_WIDTH  next hart to fetch (arbiter nxt).
- stall_i  in  1  decode cannot accept.
- redirect_valid_i  in  1  PC redirect (jump/branch).
- redirect_hart_i  in  THREAD_ADDR_WIDTH  redirected hart.
- redirect_pc_i  in  32  redirect target.
- instr_req_o  out  1  instruction memory request.
- instr_addr_o  out  32  request address.
- instr_gnt_i  in  1  request accepted.
- instr_rvalid_i  in  1  response valid.
- instr_rdata_i  in  32  response data.
- instr_valid_o  out  1  fetched instruction valid to decode.
- instr_o  out  32  fetched instruction.
- pc_o  out  32  PC of instr_o.
- hart_o  out  THREAD_ADDR_WIDTH  hart of instr_o.
- busy_o  out  1  state != IDLE.
- fetch_cnt_o  out  32  delivered-instruction count (REQ-016).

Function
REQ-003 SHALL hold a PC file of NUM_THREADS x 32-bit registers, one per hart.
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, HOLD.
- IDLE: when enable=1 and stall_i=0, latch hart=hart_sel_i and addr=pc[hart_sel_i]; go to REQ. Otherwise remain.
- REQ: drive instr_req_o=1 and instr_addr_o=latched addr; both stay stable until instr_gnt_i=1; on gnt go to WAIT.
- WAIT: on instr_rvalid_i, register instr_rdata_i, pc_o, hart_o and set instr_valid_o next cycle.
  - If stall_i=0 at rvalid: go to IDLE.
  - If stall_i=1 at rvalid: go to HOLD.
- HOLD: instr_valid_o, instr_o, pc_o and hart_o stay stable while stall_i=1; on stall_i=0 drop valid and go to IDLE.
REQ-005 instr_valid_o SHALL be a one-cycle pulse per delivered instruction, except when held in HOLD.
REQ-006 Minimum latency SHALL be: IDLE select at cycle 0, req at cycle 1 with same-cycle gnt, rvalid at cycle 2, instr_valid_o at cycle 3.
REQ-007 pc[hart] SHALL increment by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) on the cycle the instruction is delivered to decode.
REQ-008 On redirect_valid_i, pc[redirect_hart_i] SHALL load redirect_pc_i at the next edge, in any state.
REQ-009 Redirect and increment on the same hart in the same cycle: the redirect SHALL win.
REQ-010 Redirect targeting the latched hart while in REQ or WAIT SHALL set a kill flag.
- The request still completes (no request retraction).
- On rvalid the response SHALL be discarded: no instr_valid_o, no PC increment; FSM goes to IDLE.
REQ-011 Redirect targeting the latched hart while in HOLD SHALL drop instr_valid_o at the next edge and go to IDLE.
REQ-012 A redirect for any other hart SHALL only update that hart's PC and SHALL NOT disturb the fetch in flight.
REQ-013 enable=0 SHALL block new fetches only; outstanding REQ/WAIT/HOLD SHALL complete.

Reset
REQ-014 On rst=0 (asynchronous), the block SHALL reset to:
- all pc = BOOT_ADDR; FSM = IDLE; kill = 0.
- instr_req_o = 0, instr_valid_o = 0, busy_o = 0.
- instr_addr_o, instr_o, pc_o, hart_o, fetch_cnt_o = 0.
REQ-015 Reset mid-transaction SHALL abandon the outstanding request; any rvalid in the first cycle after reset release SHALL be ignored.

Configuration
REQ-016 Macro FETCH_PERF_CNT_EN:
- Defined: fetch_cnt_o SHALL increment on each delivered instruction (valid pulse or HOLD release) and saturate at 32'hFFFF_FFFF; killed fetches are not counted.
- Undefined: fetch_cnt_o SHALL be constant 0 and no counter logic is synthesized.

Verification
REQ-017 Reset, enable=1, hart_sel_i=2, gnt immediate, rvalid next cycle with data 32'h00000013 -> instr_addr_o=32'h80; instr_valid_o at cycle 3 with instr_o=32'h13, hart_o=2; pc[2]=32'h84.
REQ-018 gnt withheld 3 cycles -> instr_req_o and instr_addr_o stable for 4 cycles; a single valid pulse follows.
REQ-019 stall_i=1 at rvalid for 5 cycles -> instr_valid_o held 5 cycles with stable outputs; PC increments once, on release.
REQ-020 Redirect hart 1 to 32'h200 while hart 1 is in WAIT -> response discarded, no valid; next fetch of hart 1 uses address 32'h200.
REQ-021 Redirect hart 3 to 32'h400 while hart 0 is in flight -> hart 0 delivered normally; pc[3]=32'h400.
REQ-022 FETCH_PERF_CNT_EN defined, 10 deliveries and 1 killed fetch -> fetch_cnt_o=10; with the macro undefined -> fetch_cnt_o=0.
